// File: rtl/id_ex_pkg.sv
// Shared definitions for the ID/EX stage and the 16-bit execute ALU.
// Widths, ALU operation encodings and the hardwired-zero register index.
package id_ex_pkg;

    localparam int DATA_W = 16;
    localparam int REG_AW = 3;
    localparam int OP_W   = 2;
    localparam int CNT_W  = 16;

    typedef enum logic [OP_W-1:0] {
        ALU_OP_AND = 2'd0,
        ALU_OP_ADD = 2'd1,
        ALU_OP_SUB = 2'd2
    } alu_op_e;

    localparam logic [REG_AW-1:0] REG_R0 = '0;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand forwarding mux: picks the youngest in-flight producer of a source
// register, falling back to the value captured in the ID/EX register.
module fwd_mux #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3
) (
    input  logic [REG_AW-1:0] rs_i,
    input  logic [DATA_W-1:0] stored_val_i,
    input  logic              exmem_valid_i,
    input  logic              exmem_rd_we_i,
    input  logic              exmem_mem_rd_i,
    input  logic [REG_AW-1:0] exmem_rd_i,
    input  logic [DATA_W-1:0] exmem_result_i,
    input  logic              memwb_valid_i,
    input  logic              memwb_rd_we_i,
    input  logic [REG_AW-1:0] memwb_rd_i,
    input  logic [DATA_W-1:0] memwb_result_i,
    output logic [DATA_W-1:0] fwd_val_o
);
    import id_ex_pkg::*;

    logic exmem_hit;
    logic memwb_hit;

    // A load in EX/MEM has no data yet; the hazard logic keeps it from mattering.
    assign exmem_hit = exmem_valid_i && exmem_rd_we_i && !exmem_mem_rd_i && (exmem_rd_i == rs_i);
    assign memwb_hit = memwb_valid_i && memwb_rd_we_i && (memwb_rd_i == rs_i);

    always_comb begin
        fwd_val_o = stored_val_i;
        if (rs_i == REG_AW'(REG_R0)) begin
            fwd_val_o = '0;
        end else if (exmem_hit) begin
            fwd_val_o = exmem_result_i;
        end else if (memwb_hit) begin
            fwd_val_o = memwb_result_i;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, load-use bubble insertion
// and a saturating bubble counter for performance debug.
module id_ex_stage #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3,
    parameter int OP_W   = 2,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [OP_W-1:0]   in_alu_op,
    input  logic [REG_AW-1:0] in_rs1,
    input  logic [REG_AW-1:0] in_rs2,
    input  logic [REG_AW-1:0] in_rd,
    input  logic              in_rs1_used,
    input  logic              in_rs2_used,
    input  logic [DATA_W-1:0] in_rs1_val,
    input  logic [DATA_W-1:0] in_rs2_val,
    input  logic [DATA_W-1:0] in_imm,
    input  logic              in_use_imm,
    input  logic              in_rd_we,
    input  logic              in_mem_rd,
    input  logic              in_mem_wr,
    input  logic              exmem_valid,
    input  logic              exmem_rd_we,
    input  logic              exmem_mem_rd,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic [DATA_W-1:0] exmem_result,
    input  logic              memwb_valid,
    input  logic              memwb_rd_we,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic [DATA_W-1:0] memwb_result,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    output logic              out_valid,
    output logic              out_rd_we,
    output logic              out_mem_rd,
    output logic              out_mem_wr,
    output logic [REG_AW-1:0] out_rd,
    output logic [DATA_W-1:0] out_store_data,
    output logic              hazard_stall,
    output logic [CNT_W-1:0]  bubble_cnt
);
    import id_ex_pkg::*;

    // Source-used flags only qualify the hazard check on the ID side, so they are not carried.
    logic              valid_q,   valid_d;
    logic [OP_W-1:0]   op_q,      op_d;
    logic [REG_AW-1:0] rs1_q,     rs1_d;
    logic [REG_AW-1:0] rs2_q,     rs2_d;
    logic [REG_AW-1:0] rd_q,      rd_d;
    logic [DATA_W-1:0] rs1_val_q, rs1_val_d;
    logic [DATA_W-1:0] rs2_val_q, rs2_val_d;
    logic [DATA_W-1:0] imm_q,     imm_d;
    logic              use_imm_q, use_imm_d;
    logic              rd_we_q,   rd_we_d;
    logic              mem_rd_q,  mem_rd_d;
    logic              mem_wr_q,  mem_wr_d;
    logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;

    logic [DATA_W-1:0] fwd_a;
    logic [DATA_W-1:0] fwd_b;

    fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_a (
        .rs_i           (rs1_q),
        .stored_val_i   (rs1_val_q),
        .exmem_valid_i  (exmem_valid),
        .exmem_rd_we_i  (exmem_rd_we),
        .exmem_mem_rd_i (exmem_mem_rd),
        .exmem_rd_i     (exmem_rd),
        .exmem_result_i (exmem_result),
        .memwb_valid_i  (memwb_valid),
        .memwb_rd_we_i  (memwb_rd_we),
        .memwb_rd_i     (memwb_rd),
        .memwb_result_i (memwb_result),
        .fwd_val_o      (fwd_a)
    );

    fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_b (
        .rs_i           (rs2_q),
        .stored_val_i   (rs2_val_q),
        .exmem_valid_i  (exmem_valid),
        .exmem_rd_we_i  (exmem_rd_we),
        .exmem_mem_rd_i (exmem_mem_rd),
        .exmem_rd_i     (exmem_rd),
        .exmem_result_i (exmem_result),
        .memwb_valid_i  (memwb_valid),
        .memwb_rd_we_i  (memwb_rd_we),
        .memwb_rd_i     (memwb_rd),
        .memwb_result_i (memwb_result),
        .fwd_val_o      (fwd_b)
    );

    assign hazard_stall = valid_q && mem_rd_q && rd_we_q && (rd_q != REG_AW'(REG_R0)) && in_valid &&
                          ((in_rs1_used && (in_rs1 == rd_q)) || (in_rs2_used && (in_rs2 == rd_q)));

    always_comb begin
        valid_d      = valid_q;
        op_d         = op_q;
        rs1_d        = rs1_q;
        rs2_d        = rs2_q;
        rd_d         = rd_q;
        rs1_val_d    = rs1_val_q;
        rs2_val_d    = rs2_val_q;
        imm_d        = imm_q;
        use_imm_d    = use_imm_q;
        rd_we_d      = rd_we_q;
        mem_rd_d     = mem_rd_q;
        mem_wr_d     = mem_wr_q;
        bubble_cnt_d = bubble_cnt_q;
        if (flush) begin
            valid_d  = 1'b0;
            rd_we_d  = 1'b0;
            mem_rd_d = 1'b0;
            mem_wr_d = 1'b0;
        end else if (stall) begin
            // Capture producers that retire while held so their data survives the stall.
            rs1_val_d = fwd_a;
            rs2_val_d = fwd_b;
        end else if (hazard_stall) begin
            valid_d  = 1'b0;
            rd_we_d  = 1'b0;
            mem_rd_d = 1'b0;
            mem_wr_d = 1'b0;
            if (bubble_cnt_q != '1) begin
                bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
            end
        end else begin
            valid_d   = in_valid;
            op_d      = in_alu_op;
            rs1_d     = in_rs1;
            rs2_d     = in_rs2;
            rd_d      = in_rd;
            rs1_val_d = in_rs1_val;
            rs2_val_d = in_rs2_val;
            imm_d     = in_imm;
            use_imm_d = in_use_imm;
            rd_we_d   = in_rd_we  && in_valid;
            mem_rd_d  = in_mem_rd && in_valid;
            mem_wr_d  = in_mem_wr && in_valid;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q      <= 1'b0;
            op_q         <= '0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            rd_q         <= '0;
            rs1_val_q    <= '0;
            rs2_val_q    <= '0;
            imm_q        <= '0;
            use_imm_q    <= 1'b0;
            rd_we_q      <= 1'b0;
            mem_rd_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
            bubble_cnt_q <= '0;
        end else begin
            valid_q      <= valid_d;
            op_q         <= op_d;
            rs1_q        <= rs1_d;
            rs2_q        <= rs2_d;
            rd_q         <= rd_d;
            rs1_val_q    <= rs1_val_d;
            rs2_val_q    <= rs2_val_d;
            imm_q        <= imm_d;
            use_imm_q    <= use_imm_d;
            rd_we_q      <= rd_we_d;
            mem_rd_q     <= mem_rd_d;
            mem_wr_q     <= mem_wr_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign alu_a          = fwd_a;
    assign alu_b          = use_imm_q ? imm_q : fwd_b;
    assign out_store_data = fwd_b;
    assign alu_op         = op_q;
    assign out_valid      = valid_q;
    assign out_rd_we      = rd_we_q;
    assign out_mem_rd     = mem_rd_q;
    assign out_mem_wr     = mem_wr_q;
    assign out_rd         = rd_q;
    assign bubble_cnt     = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: table of single-instruction forwarding vectors
// followed by hand-written load-use, stall, flush, saturation and reset sequences.
module tb_id_ex_stage;
    import id_ex_pkg::*;

    // Narrow counter keeps the saturation walk short; the all-ones limit is the same logic.
    localparam int TB_CNT_W = 8;
    localparam logic [TB_CNT_W-1:0] SAT = '1;

    logic        clk, reset, stall, flush;
    logic        in_valid, in_rs1_used, in_rs2_used, in_use_imm, in_rd_we, in_mem_rd, in_mem_wr;
    logic [1:0]  in_alu_op;
    logic [2:0]  in_rs1, in_rs2, in_rd;
    logic [15:0] in_rs1_val, in_rs2_val, in_imm;
    logic        exmem_valid, exmem_rd_we, exmem_mem_rd;
    logic [2:0]  exmem_rd;
    logic [15:0] exmem_result;
    logic        memwb_valid, memwb_rd_we;
    logic [2:0]  memwb_rd;
    logic [15:0] memwb_result;
    logic [15:0] alu_a, alu_b, out_store_data;
    logic [1:0]  alu_op;
    logic        out_valid, out_rd_we, out_mem_rd, out_mem_wr, hazard_stall;
    logic [2:0]  out_rd;
    logic [TB_CNT_W-1:0] bubble_cnt;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic vld; logic [1:0] op; logic [2:0] rs1; logic [2:0] rs2; logic [2:0] rd;
        logic u1; logic u2; logic [15:0] v1; logic [15:0] v2; logic [15:0] imm;
        logic uimm; logic we; logic mrd; logic mwr;
        logic xv; logic xwe; logic xmrd; logic [2:0] xrd; logic [15:0] xres;
        logic wv; logic wwe; logic [2:0] wrd; logic [15:0] wres;
        logic [15:0] e_a; logic [15:0] e_b; logic [15:0] e_sd; logic [1:0] e_op;
        logic e_vld; logic e_we; logic e_mrd; logic e_mwr; logic [2:0] e_rd;
    } vec_t;

    vec_t vecs[9];

    id_ex_stage #(.DATA_W(16), .REG_AW(3), .OP_W(2), .CNT_W(TB_CNT_W)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_alu_op(in_alu_op),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_rs1_used(in_rs1_used), .in_rs2_used(in_rs2_used),
        .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
        .in_imm(in_imm), .in_use_imm(in_use_imm),
        .in_rd_we(in_rd_we), .in_mem_rd(in_mem_rd), .in_mem_wr(in_mem_wr),
        .exmem_valid(exmem_valid), .exmem_rd_we(exmem_rd_we), .exmem_mem_rd(exmem_mem_rd),
        .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_valid(memwb_valid), .memwb_rd_we(memwb_rd_we),
        .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .out_valid(out_valid), .out_rd_we(out_rd_we), .out_mem_rd(out_mem_rd), .out_mem_wr(out_mem_wr),
        .out_rd(out_rd), .out_store_data(out_store_data),
        .hazard_stall(hazard_stall), .bubble_cnt(bubble_cnt)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive_id(input vec_t v);
        in_valid = v.vld; in_alu_op = v.op;
        in_rs1 = v.rs1; in_rs2 = v.rs2; in_rd = v.rd;
        in_rs1_used = v.u1; in_rs2_used = v.u2;
        in_rs1_val = v.v1; in_rs2_val = v.v2;
        in_imm = v.imm; in_use_imm = v.uimm;
        in_rd_we = v.we; in_mem_rd = v.mrd; in_mem_wr = v.mwr;
    endtask

    task automatic idle_id();
        vec_t v;
        v = '0;
        drive_id(v);
    endtask

    task automatic set_prod(input vec_t v);
        exmem_valid = v.xv; exmem_rd_we = v.xwe; exmem_mem_rd = v.xmrd;
        exmem_rd = v.xrd; exmem_result = v.xres;
        memwb_valid = v.wv; memwb_rd_we = v.wwe; memwb_rd = v.wrd; memwb_result = v.wres;
    endtask

    task automatic idle_prod();
        vec_t v;
        v = '0;
        set_prod(v);
    endtask

    // Scoreboard compare
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        vec_t v;
        vecs[0] = '{vld:1'b1, op:ALU_OP_ADD, rs1:3'd1, rs2:3'd2, rd:3'd3, u1:1'b1, u2:1'b1,
                    v1:16'd5, v2:16'd7, we:1'b1,
                    e_a:16'd5, e_b:16'd7, e_sd:16'd7, e_op:ALU_OP_ADD, e_vld:1'b1, e_we:1'b1, e_rd:3'd3,
                    default:'0};
        vecs[1] = '{vld:1'b1, op:ALU_OP_AND, rs1:3'd2, rs2:3'd3, rd:3'd1, u1:1'b1, u2:1'b1,
                    v1:16'h1111, v2:16'd9, we:1'b1,
                    xv:1'b1, xwe:1'b1, xrd:3'd2, xres:16'h0010, wv:1'b1, wwe:1'b1, wrd:3'd2, wres:16'h0020,
                    e_a:16'h0010, e_b:16'd9, e_sd:16'd9, e_op:ALU_OP_AND, e_vld:1'b1, e_we:1'b1, e_rd:3'd1,
                    default:'0};
        vecs[2] = vecs[1];
        vecs[2].xv = 1'b0;
        vecs[2].e_a = 16'h0020;
        vecs[3] = vecs[1];
        vecs[3].xmrd = 1'b1;
        vecs[3].e_a = 16'h0020;
        vecs[4] = '{vld:1'b1, op:ALU_OP_ADD, rs1:3'd0, rs2:3'd3, rd:3'd2, u1:1'b1, u2:1'b1,
                    v1:16'h1234, v2:16'd9, we:1'b1,
                    xv:1'b1, xwe:1'b1, xrd:3'd0, xres:16'hAAAA, wv:1'b1, wwe:1'b1, wrd:3'd0, wres:16'h5555,
                    e_a:16'h0000, e_b:16'd9, e_sd:16'd9, e_op:ALU_OP_ADD, e_vld:1'b1, e_we:1'b1, e_rd:3'd2,
                    default:'0};
        vecs[5] = '{vld:1'b1, op:ALU_OP_SUB, rs1:3'd1, rs2:3'd5, rd:3'd0, u1:1'b1, u2:1'b1,
                    v1:16'd3, v2:16'h0055, imm:16'hFFF0, uimm:1'b1, mwr:1'b1,
                    wv:1'b1, wwe:1'b1, wrd:3'd5, wres:16'h0077,
                    e_a:16'd3, e_b:16'hFFF0, e_sd:16'h0077, e_op:ALU_OP_SUB, e_vld:1'b1, e_mwr:1'b1, e_rd:3'd0,
                    default:'0};
        vecs[6] = '{vld:1'b0, op:ALU_OP_ADD, rs1:3'd1, rs2:3'd2, rd:3'd4, u1:1'b1, u2:1'b1,
                    v1:16'd4, v2:16'd6, we:1'b1, mrd:1'b1,
                    e_a:16'd4, e_b:16'd6, e_sd:16'd6, e_op:ALU_OP_ADD, e_rd:3'd4,
                    default:'0};
        vecs[7] = '{vld:1'b1, op:ALU_OP_ADD, rs1:3'd6, rs2:3'd6, rd:3'd7, u1:1'b1, u2:1'b1,
                    v1:16'h0ABC, v2:16'h0ABC, we:1'b1,
                    xv:1'b1, xrd:3'd6, xres:16'd1, wv:1'b1, wrd:3'd6, wres:16'd2,
                    e_a:16'h0ABC, e_b:16'h0ABC, e_sd:16'h0ABC, e_op:ALU_OP_ADD, e_vld:1'b1, e_we:1'b1, e_rd:3'd7,
                    default:'0};
        vecs[8] = '{vld:1'b1, op:ALU_OP_SUB, rs1:3'd3, rs2:3'd7, rd:3'd6, u1:1'b1, u2:1'b1,
                    v1:16'd1, v2:16'd0, we:1'b1,
                    xv:1'b1, xwe:1'b1, xrd:3'd7, xres:16'h8000, wv:1'b1, wwe:1'b1, wrd:3'd7, wres:16'd4,
                    e_a:16'd1, e_b:16'h8000, e_sd:16'h8000, e_op:ALU_OP_SUB, e_vld:1'b1, e_we:1'b1, e_rd:3'd6,
                    default:'0};

        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        idle_id();
        idle_prod();
        #2;
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset bubble_cnt", 32'(bubble_cnt), 32'd0);
        chk("reset alu_a", 32'(alu_a), 32'd0);
        chk("reset alu_b", 32'(alu_b), 32'd0);
        chk("reset alu_op", 32'(alu_op), 32'd0);
        tick();
        tick();
        reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            drive_id(vecs[i]);
            idle_prod();
            tick();
            idle_id();
            set_prod(vecs[i]);
            settle();
            chk($sformatf("v%0d alu_a", i), 32'(alu_a), 32'(vecs[i].e_a));
            chk($sformatf("v%0d alu_b", i), 32'(alu_b), 32'(vecs[i].e_b));
            chk($sformatf("v%0d store_data", i), 32'(out_store_data), 32'(vecs[i].e_sd));
            chk($sformatf("v%0d alu_op", i), 32'(alu_op), 32'(vecs[i].e_op));
            chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vecs[i].e_vld));
            chk($sformatf("v%0d out_rd_we", i), 32'(out_rd_we), 32'(vecs[i].e_we));
            chk($sformatf("v%0d out_mem_rd", i), 32'(out_mem_rd), 32'(vecs[i].e_mrd));
            chk($sformatf("v%0d out_mem_wr", i), 32'(out_mem_wr), 32'(vecs[i].e_mwr));
            chk($sformatf("v%0d out_rd", i), 32'(out_rd), 32'(vecs[i].e_rd));
            chk($sformatf("v%0d hazard_stall", i), 32'(hazard_stall), 32'd0);
        end

        // Load-use: LW R4 in ID/EX, SUB R5 = R4 - R1 in ID
        idle_prod();
        v = '{vld:1'b1, op:ALU_OP_ADD, rs1:3'd1, u1:1'b1, v1:16'h0100, imm:16'd4, uimm:1'b1,
              rd:3'd4, we:1'b1, mrd:1'b1, default:'0};
        drive_id(v);
        tick();
        v = '{vld:1'b1, op:ALU_OP_SUB, rs1:3'd4, rs2:3'd1, u1:1'b1, u2:1'b1, v1:16'h9999, v2:16'd3,
              rd:3'd5, we:1'b1, default:'0};
        drive_id(v);
        settle();
        chk("loaduse hazard_stall", 32'(hazard_stall), 32'd1);
        tick();
        exmem_valid = 1'b1; exmem_rd_we = 1'b1; exmem_mem_rd = 1'b1; exmem_rd = 3'd4; exmem_result = 16'hDEAD;
        settle();
        chk("loaduse bubble out_valid", 32'(out_valid), 32'd0);
        chk("loaduse bubble_cnt", 32'(bubble_cnt), 32'd1);
        chk("loaduse hazard cleared", 32'(hazard_stall), 32'd0);
        tick();
        idle_id();
        idle_prod();
        memwb_valid = 1'b1; memwb_rd_we = 1'b1; memwb_rd = 3'd4; memwb_result = 16'h0042;
        settle();
        chk("loaduse sub out_valid", 32'(out_valid), 32'd1);
        chk("loaduse sub alu_a", 32'(alu_a), 32'h0042);
        chk("loaduse sub alu_b", 32'(alu_b), 32'd3);
        chk("loaduse sub alu_op", 32'(alu_op), 32'(ALU_OP_SUB));

        // Stall refresh: producer of R1 retires while the consumer is held
        idle_prod();
        v = '{vld:1'b1, op:ALU_OP_ADD, rs1:3'd1, rs2:3'd3, u1:1'b1, u2:1'b1, v1:16'h0011, v2:16'd1,
              rd:3'd2, we:1'b1, default:'0};
        drive_id(v);
        tick();
        idle_id();
        stall = 1'b1;
        memwb_valid = 1'b1; memwb_rd_we = 1'b1; memwb_rd = 3'd1; memwb_result = 16'hFFFD;
        settle();
        chk("stall fwd alu_a", 32'(alu_a), 32'hFFFD);
        tick();
        idle_prod();
        settle();
        chk("stall refreshed alu_a", 32'(alu_a), 32'hFFFD);
        chk("stall hold out_valid", 32'(out_valid), 32'd1);
        tick();
        stall = 1'b0;
        settle();
        chk("stall release alu_a", 32'(alu_a), 32'hFFFD);
        chk("stall release alu_b", 32'(alu_b), 32'd1);
        chk("stall release out_rd", 32'(out_rd), 32'd2);
        chk("stall release out_valid", 32'(out_valid), 32'd1);

        // Hazard seen during stall is driven but not counted; then flush+stall
        v = '{vld:1'b1, op:ALU_OP_ADD, rs1:3'd1, u1:1'b1, imm:16'd8, uimm:1'b1,
              rd:3'd4, we:1'b1, mrd:1'b1, default:'0};
        drive_id(v);
        tick();
        v = '{vld:1'b1, op:ALU_OP_AND, rs1:3'd0, rs2:3'd4, u2:1'b1, rd:3'd6, we:1'b1, default:'0};
        drive_id(v);
        stall = 1'b1;
        settle();
        chk("stall hazard_stall", 32'(hazard_stall), 32'd1);
        tick();
        settle();
        chk("stall hazard out_valid", 32'(out_valid), 32'd1);
        chk("stall hazard out_rd", 32'(out_rd), 32'd4);
        chk("stall hazard bubble_cnt", 32'(bubble_cnt), 32'd1);
        flush = 1'b1;
        settle();
        chk("flush hazard_stall", 32'(hazard_stall), 32'd1);
        tick();
        flush = 1'b0;
        stall = 1'b0;
        idle_id();
        settle();
        chk("flush+stall out_valid", 32'(out_valid), 32'd0);
        chk("flush+stall out_mem_rd", 32'(out_mem_rd), 32'd0);
        chk("flush+stall out_rd_we", 32'(out_rd_we), 32'd0);
        chk("flush+stall bubble_cnt", 32'(bubble_cnt), 32'd1);

        // Saturation: a self-dependent load hazards every second cycle
        v = '{vld:1'b1, op:ALU_OP_ADD, rs1:3'd4, u1:1'b1, rd:3'd4, we:1'b1, mrd:1'b1, default:'0};
        for (int k = 0; k < int'(SAT) - 2; k++) begin
            drive_id(v);
            tick();
            tick();
        end
        idle_id();
        settle();
        chk("sat below limit", 32'(bubble_cnt), 32'(SAT) - 32'd1);
        for (int k = 0; k < 3; k++) begin
            drive_id(v);
            tick();
            tick();
        end
        idle_id();
        settle();
        chk("sat at limit", 32'(bubble_cnt), 32'(SAT));

        // Asynchronous reset in mid-cycle
        drive_id(vecs[0]);
        tick();
        idle_id();
        settle();
        chk("pre-reset out_valid", 32'(out_valid), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        chk("async reset out_valid", 32'(out_valid), 32'd0);
        chk("async reset bubble_cnt", 32'(bubble_cnt), 32'd0);
        chk("async reset alu_a", 32'(alu_a), 32'd0);
        #1;
        reset = 1'b0;

        // Final report
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
